counter_holder_adder: RTL and testbench

Small registered 3-bit datapath that, under a 2-bit mode select, loads the sum of two operands, counts up, holds, or counts down. It is a leaf block for lab/quiz-level designs. The result is visible on a single registered output bus. All state updates on the rising clock edge, and arithmetic wraps modulo 2^WIDTH.

---
 rtl/counter_holder_adder_pkg.sv | 24 ++
 rtl/counter_holder_adder_next.sv | 29 ++
 rtl/counter_holder_adder.sv | 45 ++++
 tb/tb_counter_holder_adder.sv | 97 +++++++++
 4 files changed

// File: rtl/counter_holder_adder_pkg.sv
// Shared definitions for the counter/holder/adder datapath: select encoding,
// the mode enumeration and the default result width.
package counter_holder_adder_pkg;

    localparam int DEFAULT_WIDTH = 3;

    localparam logic [1:0] SEL_ADD   = 2'b00;
    localparam logic [1:0] SEL_COUNT = 2'b01;
    localparam logic [1:0] SEL_HOLD  = 2'b10;
    localparam logic [1:0] SEL_DOWN  = 2'b11;

    typedef enum logic [1:0] {
        MODE_ADD   = SEL_ADD,
        MODE_COUNT = SEL_COUNT,
        MODE_HOLD  = SEL_HOLD,
        MODE_DOWN  = SEL_DOWN
    } mode_e;

    // The select bus maps one-to-one onto the mode encoding.
    function automatic mode_e sel_to_mode(input logic [1:0] sel);
        return mode_e'(sel);
    endfunction

endpackage

// File: rtl/counter_holder_adder_next.sv
// Combinational next-value logic for the accumulator. All arithmetic wraps
// modulo 2^WIDTH; the adder carry-out is intentionally dropped.
module counter_holder_adder_next
    import counter_holder_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  mode_e            mode,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] next_acc
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Select the next accumulator value for the current mode.
    always_comb begin
        next_acc = acc;
        case (mode)
            MODE_ADD:   next_acc = a + b;
            MODE_COUNT: next_acc = acc + ONE;
            MODE_HOLD:  next_acc = acc;
            MODE_DOWN:  next_acc = acc - ONE;
            default:    next_acc = 'x;
        endcase
    end

endmodule

// File: rtl/counter_holder_adder.sv
// Registered 3-bit (by default) add / count-up / hold / count-down datapath.
// The top holds only the accumulator register and its synchronous reset;
// dout is driven straight from the register, so there is no input-to-output
// combinational path.
module counter_holder_adder
    import counter_holder_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       select,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    mode_e            mode;

    assign mode = sel_to_mode(select);

    counter_holder_adder_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .mode     (mode),
        .acc      (acc_q),
        .a        (a),
        .b        (b),
        .next_acc (acc_d)
    );

    // Accumulator register; reset has priority over every mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign dout = acc_q;

endmodule

// File: tb/tb_counter_holder_adder.sv
// Directed bench for counter_holder_adder with hand-computed expected values.
module tb_counter_holder_adder;
    import counter_holder_adder_pkg::*;

    localparam int W = 3;

    logic         clk;
    logic         rst;
    logic [1:0]   select;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] dout;

    int n_checks = 0;
    int n_fails  = 0;

    counter_holder_adder #(
        .WIDTH (W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .select (select),
        .a      (a),
        .b      (b),
        .dout   (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [W-1:0] obs,
                             input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: dout=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one set of inputs, take one rising edge, then check dout.
    task automatic step(input logic r, input logic [1:0] sel,
                        input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] exp, input string tag);
        rst    = r;
        select = sel;
        a      = va;
        b      = vb;
        @(posedge clk);
        #1;
        check_val(tag, dout, exp);
    endtask

    initial begin
        rst    = 1'b1;
        select = SEL_COUNT;
        a      = '0;
        b      = '0;
        #1;

        step(1'b1, SEL_COUNT, 3'd0, 3'd0, 3'd0, "reset_cyc1");
        step(1'b1, SEL_COUNT, 3'd0, 3'd0, 3'd0, "reset_cyc2");
        step(1'b0, SEL_COUNT, 3'd0, 3'd0, 3'd1, "reset_release_count");

        step(1'b0, SEL_ADD,   3'd0, 3'd0, 3'd0, "add_0_0");
        step(1'b0, SEL_COUNT, 3'd0, 3'd0, 3'd1, "count_1");
        step(1'b0, SEL_COUNT, 3'd5, 3'd2, 3'd2, "count_2");
        step(1'b0, SEL_COUNT, 3'd0, 3'd0, 3'd3, "count_3");
        step(1'b0, SEL_COUNT, 3'd0, 3'd0, 3'd4, "count_4");

        step(1'b0, SEL_HOLD,  3'd7, 3'd0, 3'd4, "hold_1");
        step(1'b0, SEL_HOLD,  3'd0, 3'd7, 3'd4, "hold_2");
        step(1'b0, SEL_HOLD,  3'd7, 3'd7, 3'd4, "hold_3");
        step(1'b0, SEL_HOLD,  3'd1, 3'd2, 3'd4, "hold_4");

        step(1'b0, SEL_ADD,   3'd2, 3'd3, 3'd5, "add_2_3");
        step(1'b0, SEL_ADD,   3'd1, 3'd2, 3'd3, "add_1_2");
        step(1'b0, SEL_ADD,   3'd3, 3'd3, 3'd6, "add_3_3");

        step(1'b0, SEL_ADD,   3'd7, 3'd7, 3'd6, "add_7_7_wrap");
        step(1'b0, SEL_COUNT, 3'd0, 3'd0, 3'd7, "count_to_7");
        step(1'b0, SEL_COUNT, 3'd0, 3'd0, 3'd0, "count_wrap_0");
        step(1'b0, SEL_DOWN,  3'd0, 3'd0, 3'd7, "down_wrap_7");
        step(1'b0, SEL_DOWN,  3'd3, 3'd4, 3'd6, "down_6");

        step(1'b1, SEL_ADD,   3'd5, 3'd1, 3'd0, "reset_beats_add");
        step(1'b0, SEL_ADD,   3'd5, 3'd1, 3'd6, "add_5_1");
        step(1'b0, SEL_HOLD,  3'd2, 3'd2, 3'd6, "hold_at_6");
        step(1'b1, SEL_HOLD,  3'd2, 3'd2, 3'd0, "reset_mid_hold");
        step(1'b1, SEL_DOWN,  3'd0, 3'd0, 3'd0, "reset_beats_down");
        step(1'b0, SEL_DOWN,  3'd0, 3'd0, 3'd7, "down_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
